// File: rtl/data_mem_obi.sv
// Single-port 32-bit data memory with a req/gnt/rvalid handshake, byte-enable writes,
// a configurable response latency and an error response. Only one transaction is outstanding at a time.
module data_mem_obi #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req,
    output logic                  data_gnt,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic                  data_we,
    input  logic [3:0]            data_be,
    input  logic [31:0]           data_wdata,
    output logic                  data_rvalid,
    output logic [31:0]           data_rdata,
    output logic                  data_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef logic [DEPTH-1:0][31:0] mem_t;

    function automatic mem_t f_mem_init();
        mem_t m;
        m = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[IDX_W'(i)] = i;
        end
        return m;
    endfunction

    // Power-up contents are word i = i; reset deliberately leaves the array alone.
    mem_t r_mem = f_mem_init();

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic [ADDR_WIDTH-3:0] w_word;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic                  w_accept;

    assign w_word   = data_addr[ADDR_WIDTH-1:2];
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_err    = (data_addr[1:0] != 2'b00) || (64'(w_word) >= 64'(DEPTH));
    assign data_gnt = data_req & ~rst & ((r_state == S_IDLE) | (r_state == S_RESP));
    assign w_accept = data_gnt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_err   <= w_err;
                r_rdata <= (w_err || data_we) ? '0 : r_mem[w_idx];
            end
        end
    end

    // Writes commit at the accept edge, so a following read sees the new value.
    always_ff @(posedge clk) begin
        if (w_accept && data_we && !w_err) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (data_be[n]) begin
                    r_mem[w_idx][8*n +: 8] <= data_wdata[8*n +: 8];
                end
            end
        end
    end

    assign data_rvalid = (r_state == S_RESP);
    assign data_rdata  = data_rvalid ? r_rdata : '0;
    assign data_err    = data_rvalid & r_err;

endmodule

// File: tb/tb_data_mem_obi.sv
// Bench for data_mem_obi: three instances (LATENCY 1, 3, 4) checked against an expected-response
// queue that records each accepted request's due cycle and result.
module tb_data_mem_obi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [3];
    logic        req    [3];
    logic        gnt    [3];
    logic [31:0] addr   [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] wdata  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    data_mem_obi #(.DEPTH(256), .ADDR_WIDTH(32), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst[0]), .data_req(req[0]), .data_gnt(gnt[0]), .data_addr(addr[0]),
        .data_we(we[0]), .data_be(be[0]), .data_wdata(wdata[0]), .data_rvalid(rvalid[0]),
        .data_rdata(rdata[0]), .data_err(err[0]));

    data_mem_obi #(.DEPTH(256), .ADDR_WIDTH(32), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst[1]), .data_req(req[1]), .data_gnt(gnt[1]), .data_addr(addr[1]),
        .data_we(we[1]), .data_be(be[1]), .data_wdata(wdata[1]), .data_rvalid(rvalid[1]),
        .data_rdata(rdata[1]), .data_err(err[1]));

    data_mem_obi #(.DEPTH(256), .ADDR_WIDTH(32), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst[2]), .data_req(req[2]), .data_gnt(gnt[2]), .data_addr(addr[2]),
        .data_we(we[2]), .data_be(be[2]), .data_wdata(wdata[2]), .data_rvalid(rvalid[2]),
        .data_rdata(rdata[2]), .data_err(err[2]));

    typedef struct {
        int unsigned u;
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        q[$];
    vec_t        vecs[13];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned lat(input int unsigned u);
        case (u)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Response monitor: every rvalid must match the queue head exactly on its due cycle.
    always @(negedge clk) begin
        for (int unsigned u = 0; u < 3; u++) begin
            if (rvalid[u] === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rvalid_unexpected: unit %0d rvalid at cycle %0d, expected none", u, cyc);
                end else if (q[0].u != u || q[0].due != cyc) begin
                    fails++;
                    $display("FAIL rvalid_timing: unit %0d rvalid at cycle %0d, expected unit %0d at cycle %0d",
                             u, cyc, q[0].u, q[0].due);
                end else begin
                    check($sformatf("rdata_u%0d", u), rdata[u], q[0].rdata);
                    check($sformatf("err_u%0d", u), {31'b0, err[u]}, {31'b0, q[0].err});
                    void'(q.pop_front());
                end
            end else begin
                check($sformatf("idle_outputs_u%0d", u), rdata[u] | {31'b0, err[u]}, 32'h0);
            end
        end
        if (q.size() != 0 && q[0].due < cyc) begin
            tests++;
            fails++;
            $display("FAIL rvalid_missing: unit %0d no rvalid by cycle %0d, expected at cycle %0d",
                     q[0].u, cyc, q[0].due);
            void'(q.pop_front());
        end
    end

    // Drives a request from posedge+1 and holds it until granted; returns cycles spent waiting.
    task automatic issue(input int unsigned u, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         output int unsigned waited);
        exp_t e;
        bit   done;
        req[u] = 1'b1; we[u] = w; addr[u] = a; be[u] = b; wdata[u] = d;
        waited = 0;
        done   = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (gnt[u] === 1'b1) begin
                e.u = u; e.due = cyc + lat(u); e.rdata = er; e.err = ee;
                q.push_back(e);
                done = 1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: unit %0d addr %h never granted, expected grant", u, a);
        end
    endtask

    task automatic idle(input int unsigned u);
        req[u] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        for (int unsigned u = 0; u < 3; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; addr[u] = '0; we[u] = 1'b0; be[u] = '0; wdata[u] = '0;
        end

        vecs[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h00BB_00DD, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0402, 4'h0, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0400, 4'h0, 32'h0,         32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0400, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0000_03FC, 4'h0, 32'h0,         32'h0000_00FF, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'h0000_0001, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0001, 4'hF, 32'h5555_5555, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_0003, 4'h0, 32'h0,         32'h0,         1'b1};

        // Reset state, including no grant while reset is held even with a request pending.
        @(posedge clk);
        #1;
        for (int unsigned u = 0; u < 3; u++) req[u] = 1'b1;
        #1;
        for (int unsigned u = 0; u < 3; u++) begin
            check($sformatf("reset_gnt_u%0d", u), {31'b0, gnt[u]}, 32'h0);
            check($sformatf("reset_rvalid_u%0d", u), {31'b0, rvalid[u]}, 32'h0);
        end
        @(posedge clk);
        #1;
        for (int unsigned u = 0; u < 3; u++) begin
            rst[u] = 1'b0;
            req[u] = 1'b0;
        end
        @(posedge clk);
        #1;

        // Table vectors on the LATENCY=1 instance, one idle cycle between transactions.
        for (int i = 0; i < 13; i++) begin
            issue(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err, w);
            check($sformatf("vec%0d_gnt_wait", i), w, 32'd0);
            idle(0);
        end

        // Back-to-back write then read of the same word; the read is granted in the RESP cycle.
        issue(0, 1'b1, 32'h0000_0030, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, w);
        check("b2b_wr_gnt_wait", w, 32'd0);
        issue(0, 1'b0, 32'h0000_0030, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, w);
        check("b2b_rd_gnt_wait", w, 32'd0);
        idle(0);

        // LATENCY=3 with request held: second grant only once the first reaches RESP.
        issue(1, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0000_0004, 1'b0, w);
        check("lat3_rd1_gnt_wait", w, 32'd0);
        issue(1, 1'b0, 32'h0000_0014, 4'h0, 32'h0, 32'h0000_0005, 1'b0, w);
        check("lat3_rd2_gnt_wait", w, 32'd2);
        idle(1);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-WAIT on LATENCY=4: response dropped, write stays committed.
        issue(2, 1'b1, 32'h0000_0008, 4'hF, 32'h1234_5678, 32'h0, 1'b0, w);
        req[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        q.delete();
        req[2] = 1'b1;
        #1;
        check("midwait_rst_gnt", {31'b0, gnt[2]}, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        req[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(2, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 32'h1234_5678, 1'b0, w);
        check("post_rst_gnt_wait", w, 32'd0);
        idle(2);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain_queue_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
